// File: rtl/conv_stream_pkg.sv
// Shared types and defaults for the 1-D convolution stream blocks.
// The engine wrappers reuse sample_t so every stage agrees on the sample format.
package conv_stream_pkg;

    localparam int CONV_WIDTH  = 8;
    localparam int CONV_LENX   = 8;
    localparam int CONV_LOGLEN = $clog2(CONV_LENX);

    typedef logic signed [CONV_WIDTH-1:0] sample_t;

    // Read-side sequencing: idle until a bank is full, then stream it out.
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/conv_x_streamer_if.sv
// Handshake bundles for the x-vector streamer: the host load port and the
// valid/ready stream towards the convolution engine's x input.

// Host-side load port: the host is the master, the streamer the slave.
interface conv_load_if #(
    parameter int WIDTH = conv_stream_pkg::CONV_WIDTH
);
    logic signed [WIDTH-1:0] wr_data;
    logic                    wr_valid;
    logic                    wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// Engine-side sample stream: the streamer is the master, the engine the slave.
interface conv_stream_if #(
    parameter int WIDTH = conv_stream_pkg::CONV_WIDTH
);
    logic signed [WIDTH-1:0] m_data_x;
    logic                    m_valid_x;
    logic                    m_ready_x;
    logic                    m_last_x;

    modport master (output m_data_x, output m_valid_x, output m_last_x, input m_ready_x);
    modport slave  (input m_data_x, input m_valid_x, input m_last_x, output m_ready_x);
endinterface

// File: rtl/conv_x_bank.sv
// One LENX-deep sample bank: synchronous write port, combinational read port.
// Contents are not reset; the streamer's full flags decide what is meaningful.
module conv_x_bank
    import conv_stream_pkg::*;
#(
    parameter int WIDTH  = CONV_WIDTH,
    parameter int LENX   = CONV_LENX,
    parameter int LOGLEN = CONV_LOGLEN
) (
    input  logic                    clk,
    input  logic                    wrEn_i,
    input  logic [LOGLEN-1:0]       wrAddr_i,
    input  logic signed [WIDTH-1:0] wrData_i,
    input  logic [LOGLEN-1:0]       rdAddr_i,
    output logic signed [WIDTH-1:0] rdData_o
);

    logic signed [WIDTH-1:0] mem_q [LENX];

    // Store the incoming sample at the write pointer when the load handshake fires.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/conv_x_streamer.sv
// Ping-pong x-vector streamer: the host fills one bank while the other is
// streamed to the convolution engine. A bank is released as soon as its last
// sample moves into the output register, so loading and streaming overlap and
// consecutive vectors leave with no bubble between them.
module conv_x_streamer
    import conv_stream_pkg::*;
#(
    parameter int WIDTH  = CONV_WIDTH,
    parameter int LENX   = CONV_LENX,
    parameter int LOGLEN = CONV_LOGLEN
) (
    input  logic          clk,
    input  logic          reset,
    conv_load_if.slave    ld,
    conv_stream_if.master st,
    output logic [15:0]   vec_sent
);

    localparam logic [LOGLEN-1:0] PTR_LAST = LOGLEN'(LENX - 1);

    logic [1:0]              full_q, full_d;
    logic                    wrBank_q, wrBank_d;
    logic [LOGLEN-1:0]       wrPtr_q, wrPtr_d;
    logic                    rdBank_q, rdBank_d;
    logic [LOGLEN-1:0]       rdPtr_q, rdPtr_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [15:0]             vecSent_q, vecSent_d;
    rd_state_t               state_q, state_d;

    logic                    wrFire;
    logic                    wrLast;
    logic                    load;
    logic                    rdLast;
    logic                    accept;
    logic signed [WIDTH-1:0] rdData0;
    logic signed [WIDTH-1:0] rdData1;
    logic signed [WIDTH-1:0] rdSample;

    // wr_ready comes purely from registered state, so a freed bank is only
    // offered to the host in the cycle after it was released.
    assign ld.wr_ready = !full_q[wrBank_q];
    assign wrFire      = ld.wr_valid && !full_q[wrBank_q];
    assign wrLast      = (wrPtr_q == PTR_LAST);

    // The output register refills whenever it is empty or being drained.
    assign load     = full_q[rdBank_q] && (!valid_q || st.m_ready_x);
    assign rdLast   = (rdPtr_q == PTR_LAST);
    assign accept   = valid_q && st.m_ready_x;
    assign rdSample = rdBank_q ? rdData1 : rdData0;

    conv_x_bank #(.WIDTH(WIDTH), .LENX(LENX), .LOGLEN(LOGLEN)) u_bank0 (
        .clk      (clk),
        .wrEn_i   (wrFire && !wrBank_q),
        .wrAddr_i (wrPtr_q),
        .wrData_i (ld.wr_data),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdData0)
    );

    conv_x_bank #(.WIDTH(WIDTH), .LENX(LENX), .LOGLEN(LOGLEN)) u_bank1 (
        .clk      (clk),
        .wrEn_i   (wrFire && wrBank_q),
        .wrAddr_i (wrPtr_q),
        .wrData_i (ld.wr_data),
        .rdAddr_i (rdPtr_q),
        .rdData_o (rdData1)
    );

    // Read-side state: stay in STREAM across a vector boundary when the other bank is ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rdBank_q]) begin
                    state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (load && rdLast && !full_q[!rdBank_q]) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Pointer, bank-flag and output-register updates; a fill and a release always hit different banks.
    always_comb begin
        full_d    = full_q;
        wrBank_d  = wrBank_q;
        wrPtr_d   = wrPtr_q;
        rdBank_d  = rdBank_q;
        rdPtr_d   = rdPtr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        vecSent_d = vecSent_q;

        if (wrFire) begin
            if (wrLast) begin
                full_d[wrBank_q] = 1'b1;
                wrPtr_d          = '0;
                wrBank_d         = !wrBank_q;
            end else begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
        end

        if (load) begin
            data_d  = rdSample;
            last_d  = rdLast;
            valid_d = 1'b1;
            if (rdLast) begin
                full_d[rdBank_q] = 1'b0;
                rdPtr_d          = '0;
                rdBank_d         = !rdBank_q;
            end else begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        if (accept && last_q) begin
            vecSent_d = vecSent_q + 16'd1;
        end
    end

    // State register; reset discards both banks and drops the stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            full_q    <= '0;
            wrBank_q  <= 1'b0;
            wrPtr_q   <= '0;
            rdBank_q  <= 1'b0;
            rdPtr_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            vecSent_q <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wrBank_q  <= wrBank_d;
            wrPtr_q   <= wrPtr_d;
            rdBank_q  <= rdBank_d;
            rdPtr_q   <= rdPtr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            vecSent_q <= vecSent_d;
        end
    end

    assign st.m_data_x  = data_q;
    assign st.m_valid_x = valid_q;
    assign st.m_last_x  = last_q;
    assign vec_sent     = vecSent_q;

endmodule

// File: tb/tb_conv_x_streamer.sv
// Directed testbench for conv_x_streamer: latency, ordering, backpressure,
// stall stability, mid-vector reset and simultaneous bank fill/release.
module tb_conv_x_streamer;
    import conv_stream_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] vecSent;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] capData [$];
    logic       capLast [$];

    conv_load_if   #(.WIDTH(8)) ld ();
    conv_stream_if #(.WIDTH(8)) st ();

    conv_x_streamer #(.WIDTH(8), .LENX(8), .LOGLEN(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .st       (st),
        .vec_sent (vecSent)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Record every sample the consumer accepts, ignoring the reset cycle.
    always @(posedge clk) begin
        if (!reset && st.m_valid_x === 1'b1 && st.m_ready_x === 1'b1) begin
            capData.push_back(st.m_data_x);
            capLast.push_back(st.m_last_x);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeSample(input logic [7:0] d);
        ld.wr_valid = 1'b1;
        ld.wr_data  = d;
        tick();
        ld.wr_valid = 1'b0;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        ld.wr_valid = 1'b0;
        ld.wr_data  = '0;
        st.m_ready_x = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        capData.delete();
        capLast.delete();
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if (ld.wr_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_wr_ready: got %0b expected 1", ld.wr_ready);
        end
        nCompared++;
        if (st.m_valid_x !== 1'b0 || st.m_last_x !== 1'b0 || st.m_data_x !== 8'h00) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%0b last=%0b data=%0h expected 0/0/00",
                     st.m_valid_x, st.m_last_x, st.m_data_x);
        end
        nCompared++;
        if (vecSent !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_vec_sent: got %0d expected 0", vecSent);
        end
    endtask

    task automatic test_basic();
        doReset();
        st.m_ready_x = 1'b1;
        for (int i = 0; i < 8; i++) writeSample(8'(i + 1));
        nCompared++;
        if (st.m_valid_x !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL basic_early_valid: got %0b expected 0", st.m_valid_x);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            nCompared++;
            if (st.m_valid_x !== 1'b1 || st.m_data_x !== 8'(k + 1) || st.m_last_x !== (k == 7)) begin
                nMismatched++;
                $display("[TB] FAIL basic_sample%0d: got valid=%0b data=%0h last=%0b expected 1/%0h/%0b",
                         k, st.m_valid_x, st.m_data_x, st.m_last_x, 8'(k + 1), (k == 7));
            end
            tick();
        end
        nCompared++;
        if (st.m_valid_x !== 1'b0 || vecSent !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL basic_end: got valid=%0b vec_sent=%0d expected 0/1", st.m_valid_x, vecSent);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp16 [16];
        doReset();
        for (int i = 0; i < 16; i++) begin
            exp16[i] = (i < 8) ? 8'(-128 + i) : 8'(120 + i - 8);
            writeSample(exp16[i]);
        end
        nCompared++;
        if (ld.wr_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_wr_ready_full: got %0b expected 0", ld.wr_ready);
        end
        writeSample(8'h63);
        nCompared++;
        if (ld.wr_ready !== 1'b0 || capData.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_17th: got wr_ready=%0b accepted=%0d expected 0/0", ld.wr_ready, capData.size());
        end
        st.m_ready_x = 1'b1;
        for (int k = 0; k < 16; k++) begin
            nCompared++;
            if (st.m_valid_x !== 1'b1 || st.m_data_x !== exp16[k] || st.m_last_x !== (k == 7 || k == 15)) begin
                nMismatched++;
                $display("[TB] FAIL b2b_sample%0d: got valid=%0b data=%0h last=%0b expected 1/%0h/%0b",
                         k, st.m_valid_x, st.m_data_x, st.m_last_x, exp16[k], (k == 7 || k == 15));
            end
            tick();
        end
        nCompared++;
        if (st.m_valid_x !== 1'b0 || vecSent !== 16'd2 || ld.wr_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_end: got valid=%0b vec_sent=%0d wr_ready=%0b expected 0/2/1",
                     st.m_valid_x, vecSent, ld.wr_ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] expData [$];
        int         wrCount = 0;
        int         cycles  = 0;
        int         seqErr  = 0;
        int         firstBad = -1;
        logic       stalled;
        logic [7:0] heldData;
        logic       heldLast;
        doReset();
        while (capData.size() < 800 && cycles < 10000) begin
            if (wrCount < 800) begin
                ld.wr_valid = 1'b1;
                ld.wr_data  = 8'($urandom_range(0, 255));
            end else begin
                ld.wr_valid = 1'b0;
            end
            st.m_ready_x = ($urandom_range(0, 1) == 1);
            stalled  = st.m_valid_x && !st.m_ready_x;
            heldData = st.m_data_x;
            heldLast = st.m_last_x;
            if (ld.wr_valid && ld.wr_ready) begin
                expData.push_back(ld.wr_data);
                wrCount++;
            end
            tick();
            cycles++;
            if (stalled) begin
                nCompared++;
                if (st.m_valid_x !== 1'b1 || st.m_data_x !== heldData || st.m_last_x !== heldLast) begin
                    nMismatched++;
                    $display("[TB] FAIL random_stall_hold: got valid=%0b data=%0h last=%0b expected 1/%0h/%0b",
                             st.m_valid_x, st.m_data_x, st.m_last_x, heldData, heldLast);
                end
            end
        end
        ld.wr_valid  = 1'b0;
        st.m_ready_x = 1'b1;
        tick();
        tick();
        nCompared++;
        if (capData.size() != 800 || expData.size() != 800) begin
            nMismatched++;
            $display("[TB] FAIL random_count: got %0d accepted (%0d written) expected 800", capData.size(), expData.size());
        end
        for (int i = 0; i < capData.size() && i < expData.size(); i++) begin
            if (capData[i] !== expData[i] || capLast[i] !== ((i % 8) == 7)) begin
                seqErr++;
                if (firstBad < 0) firstBad = i;
            end
        end
        nCompared++;
        if (seqErr != 0) begin
            nMismatched++;
            $display("[TB] FAIL random_sequence: got %0d wrong samples (first at %0d) expected 0", seqErr, firstBad);
        end
        nCompared++;
        if (vecSent !== 16'd100) begin
            nMismatched++;
            $display("[TB] FAIL random_vec_sent: got %0d expected 100", vecSent);
        end
    endtask

    task automatic test_stall();
        doReset();
        writeSample(8'h5A);
        for (int i = 1; i < 8; i++) writeSample(8'(i));
        tick();
        for (int c = 0; c < 10; c++) begin
            nCompared++;
            if (st.m_valid_x !== 1'b1 || st.m_data_x !== 8'h5A || st.m_last_x !== 1'b0 || ld.wr_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold%0d: got valid=%0b data=%0h last=%0b wr_ready=%0b expected 1/5a/0/1",
                         c, st.m_valid_x, st.m_data_x, st.m_last_x, ld.wr_ready);
            end
            tick();
        end
        st.m_ready_x = 1'b1;
        tick();
        nCompared++;
        if (capData.size() != 1 || capData[0] !== 8'h5A || st.m_data_x !== 8'h01) begin
            nMismatched++;
            $display("[TB] FAIL stall_release: got accepted=%0d next=%0h expected 1 accept of 5a, next 01",
                     capData.size(), st.m_data_x);
        end
        for (int c = 0; c < 8; c++) tick();
        nCompared++;
        if (vecSent !== 16'd1 || st.m_valid_x !== 1'b0 || capData.size() != 8) begin
            nMismatched++;
            $display("[TB] FAIL stall_drain: got vec_sent=%0d valid=%0b accepted=%0d expected 1/0/8",
                     vecSent, st.m_valid_x, capData.size());
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        st.m_ready_x = 1'b0;
        for (int i = 0; i < 8; i++) writeSample(8'(8'h21 + i));
        for (int i = 0; i < 4; i++) writeSample(8'(8'h31 + i));
        capData.delete();
        capLast.delete();
        st.m_ready_x = 1'b1;
        while (capData.size() < 5 && guard < 50) begin
            tick();
            guard++;
        end
        nCompared++;
        if (capData.size() != 5) begin
            nMismatched++;
            $display("[TB] FAIL midreset_prefill: got %0d accepted expected 5", capData.size());
        end
        reset       = 1'b1;
        ld.wr_valid = 1'b1;
        ld.wr_data  = 8'h77;
        tick();
        nCompared++;
        if (st.m_valid_x !== 1'b0 || st.m_last_x !== 1'b0 || ld.wr_ready !== 1'b1 || vecSent !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_state: got valid=%0b last=%0b wr_ready=%0b vec_sent=%0d expected 0/0/1/0",
                     st.m_valid_x, st.m_last_x, ld.wr_ready, vecSent);
        end
        reset       = 1'b0;
        ld.wr_valid = 1'b0;
        capData.delete();
        capLast.delete();
        for (int i = 0; i < 8; i++) writeSample(8'(10 + i));
        guard = 0;
        while (capData.size() < 8 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        nCompared++;
        if (capData.size() != 8) begin
            nMismatched++;
            $display("[TB] FAIL midreset_fresh_count: got %0d accepted expected 8", capData.size());
        end
        for (int k = 0; k < 8 && k < capData.size(); k++) begin
            nCompared++;
            if (capData[k] !== 8'(10 + k) || capLast[k] !== (k == 7)) begin
                nMismatched++;
                $display("[TB] FAIL midreset_fresh%0d: got data=%0d last=%0b expected %0d/%0b",
                         k, capData[k], capLast[k], 10 + k, (k == 7));
            end
        end
        nCompared++;
        if (vecSent !== 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_vec_sent: got %0d expected 1", vecSent);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] expD;
        doReset();
        for (int i = 0; i < 8; i++) writeSample(8'(8'h11 + i));
        for (int j = 0; j < 7; j++) writeSample(8'(-1 - j));
        st.m_ready_x = 1'b1;
        for (int k = 0; k < 16; k++) begin
            expD = (k < 8) ? 8'(8'h11 + k) : 8'(-1 - (k - 8));
            nCompared++;
            if (st.m_valid_x !== 1'b1 || st.m_data_x !== expD) begin
                nMismatched++;
                $display("[TB] FAIL simul_sample%0d: got valid=%0b data=%0h expected 1/%0h",
                         k, st.m_valid_x, st.m_data_x, expD);
            end
            if (k == 7) begin
                nCompared++;
                if (ld.wr_ready !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL simul_bank_freed: got wr_ready=%0b expected 1", ld.wr_ready);
                end
            end
            if (k == 6) begin
                ld.wr_valid = 1'b1;
                ld.wr_data  = 8'(-8);
            end else begin
                ld.wr_valid = 1'b0;
            end
            tick();
        end
        nCompared++;
        if (st.m_valid_x !== 1'b0 || vecSent !== 16'd2 || ld.wr_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL simul_end: got valid=%0b vec_sent=%0d wr_ready=%0b expected 0/2/1",
                     st.m_valid_x, vecSent, ld.wr_ready);
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        ld.wr_valid  = 1'b0;
        ld.wr_data   = '0;
        st.m_ready_x = 1'b0;
        $display("[TB] starting conv_x_streamer bench");
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_stall();
        test_mid_reset();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
